// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the kernel entry address used by fetch redirection.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] CP0_PC_KERNEL  = 32'h0000_4180;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers plus interrupt-vs-exception
// arbitration for the instruction currently in the M stage.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2021,
    parameter logic [31:0] PC_KERNEL  = CP0_PC_KERNEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_exc_code,
    input  logic        M_DB,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        int_exc_req
);

    // The kernel entry is fetched as an instruction, so it has to be word aligned.
    if (PC_KERNEL[1:0] != 2'b00) begin : g_pc_kernel_check
        $error("cp0_unit: PC_KERNEL must be word aligned");
    end

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic        irq;
    logic        exc;
    logic [31:0] epc_target;
    logic [31:0] sr_value;
    logic [31:0] cause_value;

    assign irq         = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc         = (M_exc_code != EXC_INT) & ~sr_exl;
    assign int_exc_req = irq | exc;
    assign epc_target  = M_DB ? (M_PC - 32'd4) : M_PC;
    assign epc_out     = epc_q;

    always_comb begin
        sr_value    = '0;
        cause_value = '0;
        sr_value[SR_IM_HI:SR_IM_LO]           = sr_im;
        sr_value[SR_EXL_BIT]                  = sr_exl;
        sr_value[SR_IE_BIT]                   = sr_ie;
        cause_value[CAUSE_BD_BIT]             = cause_bd;
        cause_value[CAUSE_IP_HI:CAUSE_IP_LO]  = cause_ip;
        cause_value[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
        case (cp0_addr)
            CP0_REG_SR:    cp0_rdata = sr_value;
            CP0_REG_CAUSE: cp0_rdata = cause_value;
            CP0_REG_EPC:   cp0_rdata = epc_q;
            CP0_REG_PRID:  cp0_rdata = PRID_VALUE;
            default:       cp0_rdata = '0;
        endcase
    end

    // A taken request flushes the M instruction, so its mtc0/eret must not land.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hw_int;
            if (int_exc_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= irq ? EXC_INT : M_exc_code;
                cause_bd  <= M_DB;
                epc_q     <= epc_target & WORD_ALIGN_MASK;
            end else begin
                if (cp0_we) begin
                    case (cp0_addr)
                        CP0_REG_SR: begin
                            sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                            sr_exl <= cp0_wdata[SR_EXL_BIT];
                            sr_ie  <= cp0_wdata[SR_IE_BIT];
                        end
                        CP0_REG_EPC: epc_q <= cp0_wdata & WORD_ALIGN_MASK;
                        default: ;
                    endcase
                end
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit: interrupts, exceptions, eret,
// delay-slot EPC, flush-suppressed writes and reset recovery.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    localparam logic [31:0] PRID = 32'h0000_2021;

    logic        clk;
    logic        reset;
    logic [31:0] M_PC;
    logic [4:0]  M_exc_code;
    logic        M_DB;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        int_exc_req;

    int checks = 0;
    int errors = 0;

    cp0_unit #(.PRID_VALUE(PRID), .PC_KERNEL(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .M_PC(M_PC), .M_exc_code(M_exc_code),
        .M_DB(M_DB), .hw_int(hw_int), .cp0_addr(cp0_addr), .cp0_we(cp0_we),
        .cp0_wdata(cp0_wdata), .eret(eret), .cp0_rdata(cp0_rdata),
        .epc_out(epc_out), .int_exc_req(int_exc_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        M_PC = 32'h0; M_exc_code = 5'd0; M_DB = 1'b0;
        cp0_we = 1'b0; cp0_wdata = 32'h0; eret = 1'b0; cp0_addr = 5'd0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4] = '{32'h0, 32'h0, 32'h0, PRID};
        idle_inputs();
        hw_int = 6'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cp0_addr = 5'(12 + i); #1;
            checks++;
            if (cp0_rdata !== exp_rd[i]) begin
                errors++;
                $display("[TB] FAIL reset_read_%0d: got %h expected %h", 12 + i, cp0_rdata, exp_rd[i]);
            end
        end
        cp0_addr = 5'd3; #1;
        checks++;
        if (cp0_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got %h expected %h", cp0_rdata, 32'h0);
        end
        checks++;
        if (int_exc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req: got %b expected 0", int_exc_req);
        end
    endtask

    task automatic test_interrupt();
        cp0_we = 1'b1; cp0_addr = CP0_REG_SR; cp0_wdata = 32'h0000_0401;
        hw_int = 6'b000001; #1;
        checks++;
        if (int_exc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_same_cycle_as_mtc0: got %b expected 0", int_exc_req);
        end
        tick();
        cp0_we = 1'b0; M_PC = 32'h0000_3000; #1;
        checks++;
        if (int_exc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_next_cycle: got %b expected 1", int_exc_req);
        end
        tick();
        M_PC = 32'h0;
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0400) begin
            errors++;
            $display("[TB] FAIL irq_cause: got %h expected %h", cp0_rdata, 32'h0000_0400);
        end
        cp0_addr = CP0_REG_SR; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0403) begin
            errors++;
            $display("[TB] FAIL irq_sr_exl: got %h expected %h", cp0_rdata, 32'h0000_0403);
        end
        checks++;
        if (epc_out !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL irq_epc: got %h expected %h", epc_out, 32'h0000_3000);
        end
    endtask

    task automatic test_exl_block_and_eret();
        M_exc_code = EXC_ADEL; #1;
        checks++;
        if (int_exc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exl_blocks_req: got %b expected 0", int_exc_req);
        end
        tick();
        M_exc_code = 5'd0;
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0400) begin
            errors++;
            $display("[TB] FAIL exl_cause_unchanged: got %h expected %h", cp0_rdata, 32'h0000_0400);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0; M_PC = 32'h0000_4180;
        cp0_addr = CP0_REG_SR; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0401) begin
            errors++;
            $display("[TB] FAIL eret_clears_exl: got %h expected %h", cp0_rdata, 32'h0000_0401);
        end
        checks++;
        if (int_exc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_after_eret: got %b expected 1", int_exc_req);
        end
        tick();
        checks++;
        if (epc_out !== 32'h0000_4180) begin
            errors++;
            $display("[TB] FAIL bubble_irq_epc: got %h expected %h", epc_out, 32'h0000_4180);
        end
        M_PC = 32'h0; hw_int = 6'd0; eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_exception_delay_slot();
        M_exc_code = EXC_OV; M_DB = 1'b1; M_PC = 32'h0000_3010; #1;
        checks++;
        if (int_exc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ov_req: got %b expected 1", int_exc_req);
        end
        tick();
        idle_inputs();
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h8000_0030) begin
            errors++;
            $display("[TB] FAIL ds_cause: got %h expected %h", cp0_rdata, 32'h8000_0030);
        end
        cp0_addr = CP0_REG_EPC; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_300C) begin
            errors++;
            $display("[TB] FAIL ds_epc: got %h expected %h", cp0_rdata, 32'h0000_300C);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_mtc0_suppressed();
        cp0_we = 1'b1; cp0_addr = CP0_REG_EPC; cp0_wdata = 32'h1234_5678;
        M_exc_code = EXC_RI; M_PC = 32'h0000_2008; #1;
        checks++;
        if (int_exc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ri_req: got %b expected 1", int_exc_req);
        end
        tick();
        idle_inputs();
        checks++;
        if (epc_out !== 32'h0000_2008) begin
            errors++;
            $display("[TB] FAIL flushed_mtc0_epc: got %h expected %h", epc_out, 32'h0000_2008);
        end
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0028) begin
            errors++;
            $display("[TB] FAIL ri_cause: got %h expected %h", cp0_rdata, 32'h0000_0028);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        cp0_we = 1'b1; cp0_addr = CP0_REG_EPC; cp0_wdata = 32'h1234_567B;
        tick();
        cp0_addr = CP0_REG_CAUSE; cp0_wdata = 32'hFFFF_FFFF;
        tick();
        cp0_addr = CP0_REG_PRID;
        tick();
        cp0_we = 1'b0;
        checks++;
        if (epc_out !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL mtc0_epc_aligned: got %h expected %h", epc_out, 32'h1234_5678);
        end
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0028) begin
            errors++;
            $display("[TB] FAIL cause_not_writable: got %h expected %h", cp0_rdata, 32'h0000_0028);
        end
        cp0_addr = CP0_REG_PRID; #1;
        checks++;
        if (cp0_rdata !== PRID) begin
            errors++;
            $display("[TB] FAIL prid_not_writable: got %h expected %h", cp0_rdata, PRID);
        end
    endtask

    task automatic test_priority();
        hw_int = 6'b000001; M_exc_code = EXC_OV; M_PC = 32'h0000_3020; #1;
        checks++;
        if (int_exc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_req: got %b expected 1", int_exc_req);
        end
        tick();
        idle_inputs();
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0400) begin
            errors++;
            $display("[TB] FAIL irq_over_exc_cause: got %h expected %h", cp0_rdata, 32'h0000_0400);
        end
        hw_int = 6'd0; eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset_after_exception();
        M_exc_code = EXC_ADES; M_PC = 32'h0000_3040;
        tick();
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0014) begin
            errors++;
            $display("[TB] FAIL ades_cause: got %h expected %h", cp0_rdata, 32'h0000_0014);
        end
        reset = 1'b1; cp0_we = 1'b1; cp0_addr = CP0_REG_SR; cp0_wdata = 32'h0000_FC03;
        tick();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cp0_addr = 5'(12 + i); #1;
            checks++;
            if (cp0_rdata !== 32'h0) begin
                errors++;
                $display("[TB] FAIL post_reset_read_%0d: got %h expected %h", 12 + i, cp0_rdata, 32'h0);
            end
        end
        checks++;
        if (int_exc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_req: got %b expected 0", int_exc_req);
        end
    endtask

    task automatic test_ip_unmasked();
        hw_int = 6'b100000; #1;
        checks++;
        if (int_exc_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked_irq_req: got %b expected 0", int_exc_req);
        end
        tick();
        cp0_addr = CP0_REG_CAUSE; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_8000) begin
            errors++;
            $display("[TB] FAIL ip_tracks_hw_int: got %h expected %h", cp0_rdata, 32'h0000_8000);
        end
        hw_int = 6'd0;
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exl_block_and_eret();
        test_exception_delay_slot();
        test_mtc0_suppressed();
        test_priority();
        test_reset_after_exception();
        test_ip_unmasked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
